vga_timing_gen: RTL and testbench

Parametrised VGA timing generator and pixel output stage; the successor to the fixed 640x480 pixel-logic block. Generates horizontal/vertical counters, pixel coordinates and a pixel request toward the frame source, accepts colour back after a configurable latency, and drives registered, mutually aligned RGB, sync and video-enable to the DAC pins. Also supports a pixel clock-enable, programmable sync polarity and frame/line start strobes.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, polarity constants and configuration helpers.
// Holds presets for 640x480@60 and 800x600@60 plus default widths.
// Imported by every file of the VGA output block.
package vga_pkg;

    // 640x480@60 (25.175 MHz nominal pixel clock)
    localparam int H_ACTIVE_480 = 640;
    localparam int H_FP_480     = 16;
    localparam int H_SYNC_480   = 96;
    localparam int H_BP_480     = 48;
    localparam int V_ACTIVE_480 = 480;
    localparam int V_FP_480     = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BP_480     = 33;

    // 800x600@60 (40 MHz nominal pixel clock)
    localparam int H_ACTIVE_600 = 800;
    localparam int H_FP_600     = 40;
    localparam int H_SYNC_600   = 128;
    localparam int H_BP_600     = 88;
    localparam int V_ACTIVE_600 = 600;
    localparam int V_FP_600     = 1;
    localparam int V_SYNC_600   = 4;
    localparam int V_BP_600     = 23;

    // Sync active level
    localparam bit POL_NEG = 1'b0;
    localparam bit POL_POS = 1'b1;

    localparam int COLOR_W_DEF = 8;
    localparam int CNT_W_DEF   = 11;
    localparam int LAT_MAX     = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of configurable width and depth; depth 0 is a wire.
// Latency: DEPTH enabled clk edges.
// No backpressure; holds contents while en is low, reset loads RST_VAL everywhere.
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0][W-1:0] stage;

            // Shift one position per enabled edge; reset blanks every stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage <= {DEPTH{RST_VAL}};
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: counters, pixel request, sync generation and registered DAC outputs.
// Latency: counter state at step k reaches r/g/b/hsync/vsync/videoon after step k+LAT+1.
// No backpressure; pix_en=0 freezes counters, delay line and output registers.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_480,
    parameter int H_FP     = H_FP_480,
    parameter int H_SYNC   = H_SYNC_480,
    parameter int H_BP     = H_BP_480,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int V_FP     = V_FP_480,
    parameter int V_SYNC   = V_SYNC_480,
    parameter int V_BP     = V_BP_480,
    parameter bit HS_POL   = POL_NEG,
    parameter bit VS_POL   = POL_NEG,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int LAT      = 1,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    output logic [CNT_W-1:0]   column,
    output logic [CNT_W-1:0]   row,
    output logic               req,
    output logic               line_start,
    output logic               frame_start,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               hsync,
    output logic               vsync,
    output logic               videoon
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject configurations the counters or delay line cannot represent.
    generate
        if (LAT < 0 || LAT > LAT_MAX) begin : g_bad_lat
            $error("vga_timing_gen: LAT must be 0..4");
        end
        if ((2 ** CNT_W) < max2(H_TOTAL, V_TOTAL)) begin : g_bad_cnt_w
            $error("vga_timing_gen: CNT_W too narrow for line/frame totals");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             hs_raw;
    logic             vs_raw;
    logic             req_d;
    logic             hs_d;
    logic             vs_d;

    // Raster counters: hcnt walks the line, vcnt steps on the hcnt wrap edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Stage 0: request, coordinates and level-independent sync, straight from the counters.
    assign req         = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign column      = req ? hcnt : '0;
    assign row         = req ? vcnt : '0;
    assign hs_raw      = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    assign vs_raw      = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    assign line_start  = pix_en && (hcnt == '0) && !reset;
    assign frame_start = line_start && (vcnt == '0);

    // Match the frame source's latency so sync and colour land on the same output edge.
    vga_delay_line #(
        .W       (3),
        .DEPTH   (LAT),
        .RST_VAL (3'b000)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .din   ({req, hs_raw, vs_raw}),
        .dout  ({req_d, hs_d, vs_d})
    );

    // Output register: blank colour outside the active area, apply sync polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r       <= '0;
            g       <= '0;
            b       <= '0;
            videoon <= 1'b0;
            hsync   <= ~HS_POL;
            vsync   <= ~VS_POL;
        end else if (pix_en) begin
            r       <= req_d ? red   : '0;
            g       <= req_d ? green : '0;
            b       <= req_d ? blue  : '0;
            videoon <= req_d;
            hsync   <= hs_d ? HS_POL : ~HS_POL;
            vsync   <= vs_d ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen across four configurations sharing one clock.
// Default 640x480 LAT=1, 640x480 LAT=2 colour ramp, 800x600 positive sync, tiny raster LAT=0.
// Inputs driven 1 ns after the rising edge; outputs sampled there as well.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic [7:0] col;

    int checks;
    int errors;

    // Default instance outputs
    logic [10:0] d_column, d_row;
    logic        d_req, d_line_start, d_frame_start, d_hsync, d_vsync, d_videoon;
    logic [7:0]  d_r, d_g, d_b;
    // Ramp instance (LAT=2)
    logic [10:0] p_column, p_row;
    logic        p_req, p_line_start, p_frame_start, p_hsync, p_vsync, p_videoon;
    logic [7:0]  p_r, p_g, p_b;
    logic [7:0]  src1, src2;
    // 800x600 positive-sync instance
    logic [10:0] s_column, s_row;
    logic        s_req, s_line_start, s_frame_start, s_hsync, s_vsync, s_videoon;
    logic [7:0]  s_r, s_g, s_b;
    // Tiny raster instance (LAT=0, positive sync)
    logic [10:0] m_column, m_row;
    logic        m_req, m_line_start, m_frame_start, m_hsync, m_vsync, m_videoon;
    logic [7:0]  m_r, m_g, m_b;

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .red(col), .green(col), .blue(col),
        .column(d_column), .row(d_row), .req(d_req),
        .line_start(d_line_start), .frame_start(d_frame_start),
        .r(d_r), .g(d_g), .b(d_b),
        .hsync(d_hsync), .vsync(d_vsync), .videoon(d_videoon)
    );

    vga_timing_gen #(.LAT(2)) u_ramp (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .red(src2), .green(src2), .blue(src2),
        .column(p_column), .row(p_row), .req(p_req),
        .line_start(p_line_start), .frame_start(p_frame_start),
        .r(p_r), .g(p_g), .b(p_b),
        .hsync(p_hsync), .vsync(p_vsync), .videoon(p_videoon)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE_600), .H_FP(H_FP_600), .H_SYNC(H_SYNC_600), .H_BP(H_BP_600),
        .V_ACTIVE(V_ACTIVE_600), .V_FP(V_FP_600), .V_SYNC(V_SYNC_600), .V_BP(V_BP_600),
        .HS_POL(POL_POS), .VS_POL(POL_POS)
    ) u_svga (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .red(col), .green(col), .blue(col),
        .column(s_column), .row(s_row), .req(s_req),
        .line_start(s_line_start), .frame_start(s_frame_start),
        .r(s_r), .g(s_g), .b(s_b),
        .hsync(s_hsync), .vsync(s_vsync), .videoon(s_videoon)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(POL_POS), .VS_POL(POL_POS), .LAT(0)
    ) u_small (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .red(col), .green(col), .blue(col),
        .column(m_column), .row(m_row), .req(m_req),
        .line_start(m_line_start), .frame_start(m_frame_start),
        .r(m_r), .g(m_g), .b(m_b),
        .hsync(m_hsync), .vsync(m_vsync), .videoon(m_videoon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame source for the ramp instance: two pixel-enabled registers of column[7:0].
    always @(posedge clk) begin
        if (reset) begin
            src1 <= 8'h00;
            src2 <= 8'h00;
        end else if (pix_en) begin
            src1 <= p_column[7:0];
            src2 <= src1;
        end
    end

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({d_r, d_g, d_b} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", {d_r, d_g, d_b}); end
        checks++; if (d_videoon !== 1'b0) begin errors++; $display("FAIL reset_videoon got %b want 0", d_videoon); end
        checks++; if ({d_hsync, d_vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b want 11", {d_hsync, d_vsync}); end
        checks++; if ({m_hsync, m_vsync} !== 2'b00) begin errors++; $display("FAIL reset_sync_pos got %b want 00", {m_hsync, m_vsync}); end
        checks++; if ({d_req, d_column, d_row} !== {1'b1, 11'd0, 11'd0}) begin errors++; $display("FAIL reset_coord got req=%b col=%0d row=%0d want 1 0 0", d_req, d_column, d_row); end
        checks++; if ({d_line_start, d_frame_start} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {d_line_start, d_frame_start}); end
        reset = 1'b0;
        #1;
        checks++; if ({d_line_start, d_frame_start} !== 2'b11) begin errors++; $display("FAIL release_strobes got %b want 11", {d_line_start, d_frame_start}); end
    endtask

    // Starts on the cycle where hcnt=0 just after reset release.
    task automatic test_hsync;
        int first_low, low_cnt, vo_cnt, ls_at;
        first_low = -1; low_cnt = 0; vo_cnt = 0; ls_at = -1;
        for (int n = 1; n <= 800; n++) begin
            @(posedge clk); #1;
            if (!d_hsync) begin
                if (first_low < 0) first_low = n;
                low_cnt++;
            end
            if (d_videoon) vo_cnt++;
            if (d_line_start && ls_at < 0) ls_at = n;
            if (n == 639) begin
                checks++; if (d_column !== 11'd639) begin errors++; $display("FAIL column_last got %0d want 639", d_column); end
            end
            if (n == 640) begin
                checks++; if ({d_req, d_column} !== {1'b0, 11'd0}) begin errors++; $display("FAIL column_blank got req=%b col=%0d want 0 0", d_req, d_column); end
            end
        end
        checks++; if (first_low != 658) begin errors++; $display("FAIL hsync_fall got %0d want 658", first_low); end
        checks++; if (low_cnt != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", low_cnt); end
        checks++; if (vo_cnt != 640) begin errors++; $display("FAIL videoon_width got %0d want 640", vo_cnt); end
        checks++; if (ls_at != 800) begin errors++; $display("FAIL line_period got %0d want 800", ls_at); end
        checks++; if ({d_row, d_frame_start} !== {11'd1, 1'b0}) begin errors++; $display("FAIL row1 got row=%0d fs=%b want 1 0", d_row, d_frame_start); end
    endtask

    task automatic test_reset_mid;
        bit found;
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(posedge clk); #1;
            if (d_req && d_column == 11'd300 && d_row == 11'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reset_mid_wait got timeout want col=300 row=2");
            return;
        end
        checks++; if ({d_videoon, d_r} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL pre_reset got vo=%b r=%h want 1 ff", d_videoon, d_r); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({d_r, d_g, d_b, d_videoon} !== 25'h0) begin errors++; $display("FAIL mid_reset_out got %h want 0", {d_r, d_g, d_b, d_videoon}); end
        checks++; if ({d_hsync, d_vsync} !== 2'b11) begin errors++; $display("FAIL mid_reset_sync got %b want 11", {d_hsync, d_vsync}); end
        checks++; if ({d_column, d_row, d_line_start} !== 23'h0) begin errors++; $display("FAIL mid_reset_coord got col=%0d row=%0d ls=%b want 0 0 0", d_column, d_row, d_line_start); end
        reset = 1'b0;
        #1;
        checks++; if (d_frame_start !== 1'b1) begin errors++; $display("FAIL mid_reset_fs got %b want 1", d_frame_start); end
        @(posedge clk); #1;
        checks++; if ({d_videoon, d_r} !== {1'b0, 8'h00}) begin errors++; $display("FAIL flushed_pipe got vo=%b r=%h want 0 00", d_videoon, d_r); end
        @(posedge clk); #1;
        checks++; if ({d_videoon, d_r} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL first_pixel got vo=%b r=%h want 1 ff", d_videoon, d_r); end
    endtask

    task automatic test_blank;
        int vo_cnt, viol;
        vo_cnt = 0; viol = 0;
        for (int n = 0; n < 800; n++) begin
            @(posedge clk); #1;
            if (d_videoon) begin
                vo_cnt++;
                if ({d_r, d_g, d_b} !== 24'hFFFFFF) viol++;
            end else if ({d_r, d_g, d_b} !== 24'h0) begin
                viol++;
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL blank_colour got %0d bad cycles want 0", viol); end
        checks++; if (vo_cnt != 640) begin errors++; $display("FAIL blank_active got %0d want 640", vo_cnt); end
    endtask

    task automatic test_ramp;
        bit found;
        int bad, vo_cnt, m;
        logic [7:0] exp_r;
        found = 1'b0; bad = 0; vo_cnt = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(posedge clk); #1;
            if (p_line_start) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL ramp_wait got timeout want line_start"); return; end
        for (int n = 1; n <= 1600; n++) begin
            @(posedge clk); #1;
            m = n % 800;
            exp_r = (m >= 3 && m <= 642) ? 8'((m - 3) % 256) : 8'h00;
            if (p_videoon) vo_cnt++;
            if (p_videoon !== (m >= 3 && m <= 642) || p_r !== exp_r) begin
                if (bad == 0) $display("FAIL ramp_pixel at %0d got vo=%b r=%h want r=%h", n, p_videoon, p_r, exp_r);
                bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ramp_total got %0d bad want 0", bad); end
        checks++; if (vo_cnt != 1280) begin errors++; $display("FAIL ramp_videoon got %0d want 1280", vo_cnt); end
    endtask

    task automatic test_pix_en_toggle;
        bit found;
        int ls_at, low_cnt, vo_cnt, hold_viol;
        logic [50:0] prev, cur;
        found = 1'b0; ls_at = -1; low_cnt = 0; vo_cnt = 0; hold_viol = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(posedge clk); #1;
            if (d_line_start) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL toggle_wait got timeout want line_start"); return; end
        prev = {d_r, d_g, d_b, d_hsync, d_vsync, d_videoon, d_column, d_row};
        for (int n = 1; n <= 1600; n++) begin
            @(posedge clk); #1;
            cur = {d_r, d_g, d_b, d_hsync, d_vsync, d_videoon, d_column, d_row};
            if ((n % 2 == 0) && cur !== prev) hold_viol++;
            prev = cur;
            if (!d_hsync) low_cnt++;
            if (d_videoon) vo_cnt++;
            pix_en = (n % 2 == 0);
            #1;
            if (d_line_start && ls_at < 0) ls_at = n;
        end
        pix_en = 1'b1;
        checks++; if (ls_at != 1600) begin errors++; $display("FAIL toggle_line_period got %0d want 1600", ls_at); end
        checks++; if (low_cnt != 192) begin errors++; $display("FAIL toggle_hsync got %0d want 192", low_cnt); end
        checks++; if (vo_cnt != 1280) begin errors++; $display("FAIL toggle_videoon got %0d want 1280", vo_cnt); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL toggle_hold got %0d changes want 0", hold_viol); end
    endtask

    task automatic test_svga_pol;
        bit found;
        int first_high, high_cnt, vo_cnt;
        found = 1'b0; first_high = -1; high_cnt = 0; vo_cnt = 0;
        for (int n = 0; n < 1200 && !found; n++) begin
            @(posedge clk); #1;
            if (s_line_start) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL svga_wait got timeout want line_start"); return; end
        for (int n = 1; n <= 1056; n++) begin
            @(posedge clk); #1;
            if (s_hsync) begin
                if (first_high < 0) first_high = n;
                high_cnt++;
            end
            if (s_videoon) vo_cnt++;
        end
        checks++; if (high_cnt != 128) begin errors++; $display("FAIL svga_hsync_width got %0d want 128", high_cnt); end
        checks++; if (first_high != 842) begin errors++; $display("FAIL svga_hsync_rise got %0d want 842", first_high); end
        checks++; if (vo_cnt != 800) begin errors++; $display("FAIL svga_videoon got %0d want 800", vo_cnt); end
        checks++; if (s_line_start !== 1'b1) begin errors++; $display("FAIL svga_line_period got %b want 1", s_line_start); end
    endtask

    task automatic test_small_frame;
        bit found;
        int vs_cnt, hs_cnt, vo_cnt, viol, fs_at, first_vs;
        found = 1'b0; vs_cnt = 0; hs_cnt = 0; vo_cnt = 0; viol = 0; fs_at = -1; first_vs = -1;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk); #1;
            if (m_frame_start) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL small_wait got timeout want frame_start"); return; end
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk); #1;
            if (m_vsync) begin
                if (first_vs < 0) first_vs = n;
                vs_cnt++;
            end
            if (m_hsync) hs_cnt++;
            if (m_videoon) vo_cnt++;
            else if ({m_r, m_g, m_b} !== 24'h0) viol++;
            if (m_frame_start && fs_at < 0) fs_at = n;
        end
        checks++; if (vs_cnt != 30) begin errors++; $display("FAIL small_vsync_width got %0d want 30", vs_cnt); end
        checks++; if (first_vs != 76) begin errors++; $display("FAIL small_vsync_rise got %0d want 76", first_vs); end
        checks++; if (hs_cnt != 24) begin errors++; $display("FAIL small_hsync_total got %0d want 24", hs_cnt); end
        checks++; if (vo_cnt != 32) begin errors++; $display("FAIL small_videoon got %0d want 32", vo_cnt); end
        checks++; if (viol != 0) begin errors++; $display("FAIL small_blank got %0d bad want 0", viol); end
        checks++; if (fs_at != 120) begin errors++; $display("FAIL small_frame_period got %0d want 120", fs_at); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        pix_en = 1'b1;
        col    = 8'hFF;
        test_reset;
        test_hsync;
        test_reset_mid;
        test_blank;
        test_ramp;
        test_pix_en_toggle;
        test_svga_pol;
        test_small_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
